// File: rtl/ls_pkg.sv
// ============================================================================
// Module      : ls_pkg
// Description : Encodings shared by the load-size unit and the store-size
//               merger so both sides of the datapath agree on size and state
//               codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ls_pkg;

  // Access size encodings; 2'b11 is not assigned and is treated as a word.
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;

  typedef logic [1:0] ls_size_t;

  // Load sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10
  } ls_state_t;

endpackage

`default_nettype wire

// File: rtl/ls_extract.sv
// ============================================================================
// Module      : ls_extract
// Description : Combinational lane extraction for loads. Takes the low
//               byte / halfword / full word of the memory word and extends
//               it to 32 bits. No address-offset shifting is applied.
//               Build option: LS_SIGN_EXT_EN selects sign extension for
//               byte and halfword results (zero extension otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_extract
  import ls_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] word,
  output logic [31:0] result
);

`ifdef LS_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  logic byte_fill;
  logic half_fill;

  assign byte_fill = SIGN_EXT & word[7];
  assign half_fill = SIGN_EXT & word[15];

  // Select the lane by size; anything not byte/half (including 2'b11) is a word
  always_comb begin
    result = word;
    case (size)
      LS_BYTE: result = {{24{byte_fill}}, word[7:0]};
      LS_HALF: result = {{16{half_fill}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ls_unit.sv
// ============================================================================
// Module      : ls_unit
// Description : Load-size unit for the multicycle MIPS datapath. On a start
//               request it latches address and size, holds a read strobe
//               for MEM_LATENCY cycles, captures the extracted/extended
//               word and pulses done for one cycle.
//               Build option: LS_SIGN_EXT_EN (sign-extend byte/half loads).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_unit
  import ls_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [1:0]        controleLS,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ls_out
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  // Reject unsupported configurations at elaboration
  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("ls_unit: MEM_LATENCY must be >= 1");
    end
    if (DATA_W != 32) begin : g_bad_width
      $error("ls_unit: only DATA_W == 32 is supported");
    end
  endgenerate

  ls_state_t        state;
  logic [CNT_W-1:0] cnt;
  ls_size_t         size_q;
  logic [31:0]      extracted;

  ls_extract u_extract (
    .size   (size_q),
    .word   (mem_data_in),
    .result (extracted)
  );

  // Load sequencer: IDLE accepts a request, READ waits out the memory
  // latency and captures the data, DONE raises the one-cycle completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      size_q   <= LS_WORD;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ls_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          mem_rd <= 1'b0;
          if (start) begin
            mem_addr <= addr_in;
            size_q   <= controleLS;
            cnt      <= CNT_LOAD;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ls_out <= extracted;
            mem_rd <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ls_unit.sv
// ============================================================================
// Module      : tb_ls_unit
// Description : Scoreboard bench for ls_unit. Two instances (MEM_LATENCY 1
//               and 3) share clock and reset. Directed loads push expected
//               results; a monitor pops and compares on every done pulse.
//               Honours LS_SIGN_EXT_EN for expected byte/half values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ls_unit;

  logic        clk;
  logic        reset;
  logic        start_v      [2];
  logic [31:0] addr_v       [2];
  logic [1:0]  ctl_v        [2];
  logic [31:0] mem_data_v   [2];
  logic [31:0] mem_addr_v   [2];
  logic        mem_rd_v     [2];
  logic        busy_v       [2];
  logic        done_v       [2];
  logic [31:0] ls_out_v     [2];

  logic [31:0] mdata        [2];
  int          rcnt         [2];
  int          rdn          [2];
  int          cyc;
  int          tests;
  int          fails;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  ls_unit #(.MEM_LATENCY(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .addr_in(addr_v[0]),
    .controleLS(ctl_v[0]), .mem_data_in(mem_data_v[0]),
    .mem_addr(mem_addr_v[0]), .mem_rd(mem_rd_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .ls_out(ls_out_v[0])
  );

  ls_unit #(.MEM_LATENCY(3), .DATA_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .start(start_v[1]), .addr_in(addr_v[1]),
    .controleLS(ctl_v[1]), .mem_data_in(mem_data_v[1]),
    .mem_addr(mem_addr_v[1]), .mem_rd(mem_rd_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .ls_out(ls_out_v[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data is only valid once the read strobe has been held
  // for the instance's latency; otherwise a poison pattern is returned.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_rd_v[i]) rcnt[i] <= rcnt[i] + 1;
      else             rcnt[i] <= 0;
    end
  end

  assign mem_data_v[0] = (mem_rd_v[0] && rcnt[0] == lat(0) - 1) ? mdata[0] : 32'hBAD0_BAD0;
  assign mem_data_v[1] = (mem_rd_v[1] && rcnt[1] == lat(1) - 1) ? mdata[1] : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, required %h", nm, u, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      if (!reset)          rdn[i] = 0;
      else if (mem_rd_v[i]) rdn[i]++;
      if (done_v[i]) begin
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done dut%0d: got done=1, required no pending load", i);
        end else begin
          chk("ls_out",     i, ls_out_v[i],   e.data);
          chk("mem_addr",   i, mem_addr_v[i], e.addr);
          chk("done_cycle", i, cyc,           e.cyc);
          chk("rd_cycles",  i, rdn[i],        lat(i));
          chk("busy_done",  i, {31'd0, busy_v[i]}, 32'd1);
        end
        rdn[i] = 0;
      end
    end
  end

  // Issue one load at the current negedge; holds start for one cycle then
  // scrambles the request inputs to prove they were latched.
  task automatic issue(input int u, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, input logic [31:0] expv, input bit push);
    exp_t e;
    start_v[u] = 1'b1;
    addr_v[u]  = a;
    ctl_v[u]   = sz;
    mdata[u]   = d;
    e.data = expv;
    e.addr = a;
    e.cyc  = cyc + lat(u) + 1;
    if (push) begin
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    start_v[u] = 1'b0;
    addr_v[u]  = 32'hFFFF_FFFC;
    ctl_v[u]   = ~sz;
  endtask

  task automatic wait_idle(input int u);
    int k;
    k = 0;
    while (busy_v[u] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      tests++;
      fails++;
      $display("FAIL timeout dut%0d: got busy=1 after %0d cycles, required 0", u, k);
    end
  endtask

  task automatic chk_cleared(input int u);
    chk("rst_mem_addr", u, mem_addr_v[u], 32'h0);
    chk("rst_ls_out",   u, ls_out_v[u],   32'h0);
    chk("rst_ctrl",     u, {29'd0, mem_rd_v[u], busy_v[u], done_v[u]}, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      addr_v[i]  = 32'h0;
      ctl_v[i]   = 2'b00;
      mdata[i]   = 32'h0;
      rcnt[i]    = 0;
      rdn[i]     = 0;
    end

    repeat (3) @(negedge clk);
    chk_cleared(0);
    chk_cleared(1);
    reset = 1'b1;
    @(negedge clk);

    // Word, latency 1
    issue(0, 32'h0000_0040, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    wait_idle(0);

    // Byte with bit 7 set
`ifdef LS_SIGN_EXT_EN
    issue(0, 32'h0000_0044, 2'b01, 32'h1234_5680, 32'hFFFF_FF80, 1'b1);
`else
    issue(0, 32'h0000_0044, 2'b01, 32'h1234_5680, 32'h0000_0080, 1'b1);
`endif
    wait_idle(0);

    // Halfword, positive then negative
    issue(0, 32'h0000_0048, 2'b10, 32'hAAAA_7FFF, 32'h0000_7FFF, 1'b1);
    wait_idle(0);
`ifdef LS_SIGN_EXT_EN
    issue(0, 32'h0000_004C, 2'b10, 32'hAAAA_8001, 32'hFFFF_8001, 1'b1);
`else
    issue(0, 32'h0000_004C, 2'b10, 32'hAAAA_8001, 32'h0000_8001, 1'b1);
`endif
    wait_idle(0);

    // Result held while idle
    repeat (3) @(negedge clk);
`ifdef LS_SIGN_EXT_EN
    chk("ls_out_hold", 0, ls_out_v[0], 32'hFFFF_8001);
`else
    chk("ls_out_hold", 0, ls_out_v[0], 32'h0000_8001);
`endif

    // Size 11 as word, then a request in the cycle right after DONE
    issue(0, 32'h0000_0050, 2'b11, 32'h0102_0304, 32'h0102_0304, 1'b1);
    wait_idle(0);
    issue(0, 32'h0000_0054, 2'b01, 32'hCAFE_BA7F, 32'h0000_007F, 1'b1);
    wait_idle(0);

    // Latency 3 with a second start during READ that must be ignored
`ifdef LS_SIGN_EXT_EN
    issue(1, 32'h0000_0100, 2'b10, 32'h1234_F00D, 32'hFFFF_F00D, 1'b1);
`else
    issue(1, 32'h0000_0100, 2'b10, 32'h1234_F00D, 32'h0000_F00D, 1'b1);
`endif
    start_v[1] = 1'b1;
    addr_v[1]  = 32'h0000_0200;
    ctl_v[1]   = 2'b00;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_idle(1);
    repeat (4) @(negedge clk);
    chk("addr_kept", 1, mem_addr_v[1], 32'h0000_0100);

    // Reset in the middle of READ aborts the load without a done pulse
    issue(1, 32'h0000_0300, 2'b00, 32'h1111_2222, 32'h1111_2222, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_cleared(1);
    chk_cleared(0);
    repeat (6) @(negedge clk);
    chk("ls_out_after_abort", 1, ls_out_v[1], 32'h0);

    chk("pending_q0", 0, q0.size(), 32'd0);
    chk("pending_q1", 1, q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ls_unit.md
Name: ls_unit

Overview:
- Load-size unit: the read-side counterpart of the store-size merger in the multicycle MIPS datapath.
- On a control-unit request it performs one memory read and waits out the memory latency.
- It then returns the full word, low byte or low halfword, extended to 32 bits, for write-back to the register file.
- It sits between the control unit/ALUOut address path and the data memory read port.

Parameters:
- MEM_LATENCY, 1: cycles from address presentation to valid mem_data_in. Must be >=1; 0 is rejected at elaboration.
- DATA_W, 32: data and address width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  load request, sampled only in IDLE
- addr_in  in  32  load address, latched with start
- controleLS  in  2  size: 00 word, 01 byte, 10 halfword, 11 treated as word
- mem_data_in  in  32  data memory read port
- mem_addr  out  32  address driven to memory
- mem_rd  out  1  memory read strobe
- busy  out  1  high in READ and DONE
- done  out  1  one-cycle completion pulse
- ls_out  out  32  extended load result, held until the next completion

Behaviour:
- Reset (reset==0 at a clk edge), all registered:
  - state=IDLE, cnt=0
  - mem_addr=0, mem_rd=0, busy=0, done=0, ls_out=0
  - latched size=00
- Reset has priority over all other inputs. Reset mid-operation aborts the load: no done pulse, ls_out forced to 0.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - mem_rd=0; mem_addr holds its last value.
  - start=1 at edge E0: latch addr_in into mem_addr and controleLS into size_q, set cnt=MEM_LATENCY-1, go to READ.
- READ:
  - mem_rd=1, busy=1.
  - Each edge with cnt!=0 decrements cnt.
  - Edge with cnt==0 (edge E_L, L=MEM_LATENCY): capture the extracted mem_data_in into ls_out and go to DONE.
- DONE:
  - done=1, busy=1, mem_rd=0. Lasts exactly one cycle, then go to IDLE.
- Latency: done is high in the cycle after E_L. For MEM_LATENCY=1, done is high 2 cycles after the start cycle.
- start is ignored while busy. No queueing; the control unit re-requests if needed.
- Extraction from the low bits of the word (the same lane convention as the store merger; no address-offset shifting):
  - word: ls_out=mem_data_in
  - byte: ls_out={24 ext, mem_data_in[7:0]}
  - half: ls_out={16 ext, mem_data_in[15:0]}
  - ext is 0 by default (see Optional Feature).
- Size 11 behaves exactly as word.
- ls_out changes only at a capture edge or at reset.
- addr_in and controleLS changes after E0 have no effect on the load in flight.

Optional Feature:
- LS_SIGN_EXT_EN defined: byte and halfword results are sign-extended from bit 7 and bit 15 respectively.
- Undefined: zero-extended. The word path is unaffected either way.

Decomposition:
- Shared package ls_pkg:
  - size encodings LS_WORD=2'b00, LS_BYTE=2'b01, LS_HALF=2'b10
  - state encodings IDLE=2'b00, READ=2'b01, DONE=2'b10
- The package is shared with the store-size merger so both sides use one encoding.
- One natural sub-module: ls_extract, purely combinational (size, word -> 32-bit result, honouring LS_SIGN_EXT_EN), instantiated once ahead of the ls_out register.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-READ, then release -> all outputs 0, state IDLE, no done pulse.
- Word, MEM_LATENCY=1: start, addr_in=0x0000_0040, controleLS=00, mem_data_in=0xDEAD_BEEF -> mem_addr=0x40 with mem_rd=1 for 1 cycle; done 2 cycles after start; ls_out=0xDEAD_BEEF.
- Byte: controleLS=01, mem_data_in=0x1234_5680 -> ls_out=0x0000_0080; with LS_SIGN_EXT_EN, 0xFFFF_FF80.
- Halfword: controleLS=10, mem_data_in=0xAAAA_7FFF -> ls_out=0x0000_7FFF in both builds. Repeat with 0xAAAA_8001 -> 0x0000_8001, or 0xFFFF_8001 with LS_SIGN_EXT_EN.
- Busy rejection and latency: MEM_LATENCY=3; pulse start again during READ with a different addr_in -> exactly one done, 4 cycles after the first start; mem_addr unchanged; mem_rd high for 3 cycles.
- Size 11 plus back-to-back: controleLS=11, mem_data_in=0x0102_0304 -> ls_out=0x0102_0304; start asserted in the cycle after DONE -> accepted, second done follows normally.
